exp_share_ctrl: RTL and testbench

- Controller that time-shares one exponential unit (start/x/done/intpart/fracpart) among N requesters.
- Round-robin arbitration; captures the winner's x, pulses start, waits for done with a timeout, then returns the result to the winner only.
- Sits between requester blocks and the single exponential instance.

---
 rtl/exp_share_pkg.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/exp_share_ctrl.sv | 136 +++++++++++++
 tb/tb_exp_share_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_share_pkg.sv
// rtl/exp_share_pkg.sv - shared state encoding and result widths for exp_share_ctrl
package exp_share_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int INT_W  = 2;
    localparam int FRAC_W = 16;
    localparam int XW_DEF = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or after ptr
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    int   w_pos;
    logic w_found;

    always_comb begin
        any     = |req;
        idx     = '0;
        w_pos   = 0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_pos = (int'(ptr) + k) % N;
            if (!w_found && req[w_pos]) begin
                w_found = 1'b1;
                idx     = w_pos[IW-1:0];
            end
        end
        onehot = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/exp_share_ctrl.sv
// rtl/exp_share_ctrl.sv - time-shares one exponential unit among N requesters, round-robin
module exp_share_ctrl
    import exp_share_pkg::*;
#(
    parameter int N       = 4,
    parameter int XW      = XW_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N*XW-1:0]     x_in,
    output logic [N-1:0]        gnt,
    output logic [N-1:0]        res_valid,
    output logic [INT_W-1:0]    res_int,
    output logic [FRAC_W-1:0]   res_frac,
    output logic                res_err,
    output logic                exp_start,
    output logic [XW-1:0]       exp_x,
    input  logic                exp_done,
    input  logic [INT_W-1:0]    exp_int,
    input  logic [FRAC_W-1:0]   exp_frac
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT);

    logic [1:0]        r_state;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_idx;
    logic [CW-1:0]     r_cnt;
    logic [INT_W-1:0]  r_int;
    logic [FRAC_W-1:0] r_frac;
    logic              r_err;
    logic [N-1:0]      r_gnt;
    logic [N-1:0]      r_res_valid;
    logic [INT_W-1:0]  r_res_int;
    logic [FRAC_W-1:0] r_res_frac;
    logic              r_res_err;
    logic              r_start;
    logic [XW-1:0]     r_x;

    logic              w_any;
    logic [IW-1:0]     w_idx;
    logic [N-1:0]      w_onehot;
    logic [XW-1:0]     w_x_sel;
    logic [IW-1:0]     w_ptr_next;
    logic [N-1:0]      w_idx_onehot;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_ptr),
        .any    (w_any),
        .idx    (w_idx),
        .onehot (w_onehot)
    );

    assign w_x_sel      = x_in[w_idx*XW +: XW];
    assign w_ptr_next   = (r_idx == IW'(N - 1)) ? '0 : r_idx + 1'b1;
    assign w_idx_onehot = {{(N-1){1'b0}}, 1'b1} << r_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_int       <= '0;
            r_frac      <= '0;
            r_err       <= 1'b0;
            r_gnt       <= '0;
            r_res_valid <= '0;
            r_res_int   <= '0;
            r_res_frac  <= '0;
            r_res_err   <= 1'b0;
            r_start     <= 1'b0;
            r_x         <= '0;
        end else begin
            // Pulsed outputs default low; each state raises its own for one cycle.
            r_gnt       <= '0;
            r_res_valid <= '0;
            r_start     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_idx   <= w_idx;
                        r_x     <= w_x_sel;
                        r_gnt   <= w_onehot;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_start <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (exp_done) begin
                        r_int   <= exp_int;
                        r_frac  <= exp_frac;
                        r_err   <= 1'b0;
                        r_state <= S_RESP;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_int   <= '0;
                        r_frac  <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_res_valid <= w_idx_onehot;
                    r_res_int   <= r_int;
                    r_res_frac  <= r_frac;
                    r_res_err   <= r_err;
                    r_ptr       <= w_ptr_next;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign res_valid = r_res_valid;
    assign res_int   = r_res_int;
    assign res_frac  = r_res_frac;
    assign res_err   = r_res_err;
    assign exp_start = r_start;
    assign exp_x     = r_x;

endmodule

// File: tb/tb_exp_share_ctrl.sv
// tb/tb_exp_share_ctrl.sv - randomized self-checking bench for exp_share_ctrl
module tb_exp_share_ctrl;

    localparam int N       = 4;
    localparam int XW      = 16;
    localparam int TIMEOUT = 64;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*XW-1:0] x_in;
    logic [N-1:0]    gnt;
    logic [N-1:0]    res_valid;
    logic [1:0]      res_int;
    logic [15:0]     res_frac;
    logic            res_err;
    logic            exp_start;
    logic [XW-1:0]   exp_x;
    logic            exp_done;
    logic [1:0]      exp_int;
    logic [15:0]     exp_frac;

    int n_checks = 0;
    int n_errors = 0;
    int t = 0;

    // Reference model: transaction timestamps instead of a state machine.
    bit            m_idle;
    bit            m_busy;
    bit            m_err;
    int            m_ptr;
    int            m_cur;
    int            m_g;
    int            m_res_due;
    logic [XW-1:0] m_curx;

    int stub_cnt;
    bit stub_never;
    bit rand_never;

    int          last_gnt_t;
    int          last_start_t;
    int          last_res_t;
    int          n_gnt_evt = 0;
    int          n_res_evt = 0;
    int          gnt_log[$];
    logic [15:0] frac_by_req[N];

    exp_share_ctrl #(
        .N       (N),
        .XW      (XW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .x_in      (x_in),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_int   (res_int),
        .res_frac  (res_frac),
        .res_err   (res_err),
        .exp_start (exp_start),
        .exp_x     (exp_x),
        .exp_done  (exp_done),
        .exp_int   (exp_int),
        .exp_frac  (exp_frac)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_winner(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++)
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_idle    = 1'b1;
        m_busy    = 1'b0;
        m_ptr     = 0;
        m_res_due = -1;
        stub_cnt  = 0;
        exp_done  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock: observe at the falling edge, compare with the model, then run the exp stub.
    task automatic tick();
        logic [31:0] exp_g;
        logic [31:0] exp_rv;
        int          w;
        @(negedge clk);
        t++;
        exp_g = '0;
        if (m_idle && req != '0) begin
            w         = rr_winner(req, m_ptr);
            exp_g     = 32'(1) << w;
            m_idle    = 1'b0;
            m_busy    = 1'b1;
            m_g       = t;
            m_cur     = w;
            m_curx    = x_in[w*XW +: XW];
            m_res_due = -1;
        end
        check("gnt", 32'(gnt), exp_g);
        check("exp_start", 32'(exp_start), 32'(m_busy && t == m_g + 1));
        if (m_busy && t == m_g + 1) check("exp_x", 32'(exp_x), 32'(m_curx));
        if (m_busy && m_res_due < 0 && t - 1 >= m_g + 1 && t - 1 <= m_g + TIMEOUT) begin
            if (exp_done) begin
                m_res_due = t + 1;
                m_err     = 1'b0;
            end else if (t - 1 == m_g + TIMEOUT) begin
                m_res_due = t + 1;
                m_err     = 1'b1;
            end
        end
        exp_rv = (m_busy && t == m_res_due) ? (32'(1) << m_cur) : '0;
        check("res_valid", 32'(res_valid), exp_rv);
        if (exp_rv != '0) begin
            check("res_err", 32'(res_err), 32'(m_err));
            check("res_int", 32'(res_int), m_err ? 32'd0 : 32'd1);
            check("res_frac", 32'(res_frac), m_err ? 32'd0 : 32'(m_curx));
            m_busy = 1'b0;
            m_idle = 1'b1;
            m_ptr  = (m_cur + 1) % N;
        end
        if (gnt != '0) begin
            n_gnt_evt++;
            last_gnt_t = t;
            for (int i = 0; i < N; i++) if (gnt[i]) gnt_log.push_back(i);
        end
        if (res_valid != '0) begin
            n_res_evt++;
            last_res_t = t;
            for (int i = 0; i < N; i++) if (res_valid[i]) frac_by_req[i] = res_frac;
        end
        if (exp_start) last_start_t = t;
        exp_done = 1'b0;
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0 && !stub_never) exp_done = 1'b1;
        end
        if (exp_start) begin
            stub_cnt = 8;
            exp_frac = exp_x;
            if (rand_never) stub_never = ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic run_until_res(input string tag, input int bound);
        int start_n;
        start_n = n_res_evt;
        for (int i = 0; i < bound && n_res_evt == start_n; i++) tick();
        check(tag, 32'(n_res_evt - start_n), 32'd1);
    endtask

    int g0;
    int r0;

    initial begin
        rst        = 1'b0;
        req        = '0;
        x_in       = '0;
        exp_int    = 2'b01;
        exp_frac   = '0;
        stub_never = 1'b0;
        rand_never = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_int", 32'(res_int), 32'd0);
        check("rst_res_frac", 32'(res_frac), 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);
        check("rst_exp_start", 32'(exp_start), 32'd0);
        check("rst_exp_x", 32'(exp_x), 32'd0);
        rst = 1'b1;

        // Single request
        x_in[2*XW +: XW] = 16'hED3C;
        req = 4'b0100;
        tick();
        check("single_gnt", 32'(gnt), 32'h4);
        req = '0;
        run_until_res("single_done", 40);
        check("single_lat", 32'(last_res_t - last_gnt_t), 32'd11);
        check("single_start_lat", 32'(last_start_t - last_gnt_t), 32'd1);
        check("single_frac", 32'(res_frac), 32'hED3C);
        check("single_int", 32'(res_int), 32'd1);

        // Contention with all requesters held
        do_reset();
        gnt_log.delete();
        for (int i = 0; i < N; i++) x_in[i*XW +: XW] = 16'(16'h5000 + i * 16'h1000);
        req = '1;
        repeat (5) run_until_res("cont_done", 40);
        req = '0;
        check("cont_ngnt", 32'(gnt_log.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            if (k < gnt_log.size()) check("cont_order", 32'(gnt_log[k]), 32'(k % N));
        check("cont_frac1", 32'(frac_by_req[1]), 32'h6000);

        // Timeout, then a normal request
        stub_never = 1'b1;
        x_in[0 +: XW] = 16'h0ABC;
        req = 4'b0001;
        tick();
        check("to_gnt", 32'(gnt), 32'h1);
        req = '0;
        run_until_res("to_done", TIMEOUT + 20);
        check("to_lat", 32'(last_res_t - last_start_t), 32'(TIMEOUT + 1));
        check("to_err", 32'(res_err), 32'd1);
        check("to_frac", 32'(res_frac), 32'd0);
        stub_never = 1'b0;
        x_in[1*XW +: XW] = 16'h1234;
        req = 4'b0010;
        tick();
        check("after_to_gnt", 32'(gnt), 32'h2);
        req = '0;
        run_until_res("after_to_done", 40);
        check("after_to_err", 32'(res_err), 32'd0);
        check("after_to_frac", 32'(res_frac), 32'h1234);

        // Request pulsed for one cycle only
        g0 = n_gnt_evt;
        r0 = n_res_evt;
        req = 4'b0001;
        tick();
        req = '0;
        repeat (30) tick();
        check("pulse_ngnt", 32'(n_gnt_evt - g0), 32'd1);
        check("pulse_nres", 32'(n_res_evt - r0), 32'd1);

        // Stray done while idle
        r0 = n_res_evt;
        exp_done = 1'b1;
        tick();
        repeat (5) tick();
        check("stray_nres", 32'(n_res_evt - r0), 32'd0);
        req = 4'b0100;
        tick();
        check("stray_next_gnt", 32'(gnt), 32'h4);
        req = '0;
        run_until_res("stray_next_done", 40);

        // Reset in the middle of WAIT
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        check("rw_start", 32'(exp_start), 32'd1);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rw_gnt", 32'(gnt), 32'd0);
        check("rw_res_valid", 32'(res_valid), 32'd0);
        check("rw_res_int", 32'(res_int), 32'd0);
        check("rw_res_frac", 32'(res_frac), 32'd0);
        check("rw_res_err", 32'(res_err), 32'd0);
        check("rw_exp_start", 32'(exp_start), 32'd0);
        check("rw_exp_x", 32'(exp_x), 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        r0 = n_res_evt;
        repeat (20) tick();
        check("rw_nres", 32'(n_res_evt - r0), 32'd0);
        req = '1;
        tick();
        check("rw_ptr0", 32'(gnt), 32'h1);
        req = '0;
        run_until_res("rw_done", 40);

        // Randomized traffic with occasional unit timeouts
        do_reset();
        r0 = n_res_evt;
        rand_never = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    x_in[i*XW +: XW] = 16'($urandom);
                end
            tick();
            for (int i = 0; i < N; i++)
                if (gnt[i] && $urandom_range(0, 1) == 0) req[i] = 1'b0;
        end
        rand_never = 1'b0;
        req = '0;
        repeat (100) tick();
        check("rand_ops", 32'(n_res_evt - r0 > 50), 32'd1);
        check("rand_drained", 32'(m_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
